ysyx_22040895_imm_ctrl: RTL and testbench

//  Decode-side sequencer that feeds the 64-bit immediate sign-extender.

---
 rtl/ysyx_22040895_imm_ctrl_if.sv | 26 ++
 rtl/ysyx_22040895_imm_ctrl.sv | 93 +++++++++
 tb/tb_ysyx_22040895_imm_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/ysyx_22040895_imm_ctrl_if.sv
// ysyx_22040895_imm_ctrl_if: IFU-side fetch offer and EXU-side decoded head with immediate fields
interface ysyx_22040895_imm_ctrl_if #(parameter int PC_W = 64);
    logic            inst_valid;
    logic            inst_ready;
    logic [31:0]     inst;
    logic [PC_W-1:0] pc;
    logic            flush;
    logic            dec_valid;
    logic            dec_ready;
    logic [PC_W-1:0] dec_pc;
    logic [31:0]     dec_inst;
    logic            immsel;
    logic [11:0]     imm1;
    logic [19:0]     imm2;
    logic [1:0]      imm_sh;
    logic [2:0]      fmt;
    logic            illegal;
    modport slave (
        input  inst_valid, inst, pc, flush, dec_ready,
        output inst_ready, dec_valid, dec_pc, dec_inst, immsel, imm1, imm2, imm_sh, fmt, illegal
    );
    modport master (
        output inst_valid, inst, pc, flush, dec_ready,
        input  inst_ready, dec_valid, dec_pc, dec_inst, immsel, imm1, imm2, imm_sh, fmt, illegal
    );
endinterface

// File: rtl/ysyx_22040895_imm_ctrl.sv
// ysyx_22040895_imm_ctrl: fetch FIFO that classifies the head instruction and feeds the immediate sign-extender
module ysyx_22040895_imm_ctrl #(
    parameter int DEPTH = 2,
    parameter int PC_W  = 64
) (
    input logic clk,
    input logic rst,
    ysyx_22040895_imm_ctrl_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    logic [31:0]     inst_mem [DEPTH];
    logic [PC_W-1:0] pc_mem   [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     count;
    logic            valid, push, pop;
    logic [31:0]     head;
    logic [2:0]      fmt;
    logic            sel;
    logic [11:0]     imm1;
    logic [19:0]     imm2;
    logic [1:0]      sh;
    // outputs are forced low during reset even if count has not yet cleared
    assign valid          = !rst && count != '0;
    assign bus.inst_ready = !rst && count < (AW+1)'(DEPTH);
    assign push           = bus.inst_valid && bus.inst_ready && !bus.flush;
    assign pop            = valid && bus.dec_ready && !bus.flush;
    assign head           = inst_mem[rd_ptr];
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem[wr_ptr] <= bus.inst;
            pc_mem[wr_ptr]   <= bus.pc;
        end
    end
    // opcodes ending in anything but 2'b11 fall through to the illegal default
    always_comb begin
        fmt  = valid ? 3'd7 : 3'd0;
        sel  = valid;
        imm1 = '0;
        imm2 = '0;
        sh   = 2'b00;
        if (valid) begin
            case (head[6:0])
                7'h13, 7'h03, 7'h67, 7'h1b, 7'h73, 7'h0f: begin
                    fmt  = 3'd1;
                    imm1 = head[31:20];
                end
                7'h23: begin
                    fmt  = 3'd2;
                    imm1 = {head[31:25], head[11:7]};
                end
                7'h63: begin
                    fmt  = 3'd3;
                    imm1 = {head[31], head[7], head[30:25], head[11:8]};
                    sh   = 2'b01;
                end
                7'h37, 7'h17: begin
                    fmt  = 3'd4;
                    sel  = 1'b0;
                    imm2 = head[31:12];
                    sh   = 2'b10;
                end
                7'h6f: begin
                    fmt  = 3'd5;
                    sel  = 1'b0;
                    imm2 = {head[31], head[19:12], head[20], head[30:21]};
                    sh   = 2'b01;
                end
                7'h33, 7'h3b: fmt = 3'd0;
                default: ;
            endcase
        end
    end
    assign bus.dec_valid = valid;
    assign bus.dec_pc    = valid ? pc_mem[rd_ptr] : '0;
    assign bus.dec_inst  = valid ? head : '0;
    assign bus.fmt       = fmt;
    assign bus.illegal   = valid && fmt == 3'd7;
    assign bus.immsel    = sel;
    assign bus.imm1      = imm1;
    assign bus.imm2      = imm2;
    assign bus.imm_sh    = sh;
endmodule

// File: tb/tb_ysyx_22040895_imm_ctrl.sv
// tb_ysyx_22040895_imm_ctrl: directed and random stimulus against a queue model with architectural immediates
module tb_ysyx_22040895_imm_ctrl;
    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
    } ent_t;
    logic clk = 1'b0;
    logic rst;
    ent_t q[$];
    int   checks   = 0;
    int   failures = 0;
    always #5 clk = ~clk;
    ysyx_22040895_imm_ctrl_if #(.PC_W(64)) bus ();
    ysyx_22040895_imm_ctrl #(.DEPTH(2), .PC_W(64)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    // architectural RV64I immediate first, then the field the extender needs to rebuild it
    task automatic ref_dec(input logic [31:0] i, output logic [2:0] fmt, output logic sel,
                           output logic [11:0] i1, output logic [19:0] i2, output logic [1:0] sh,
                           output logic [63:0] imm);
        imm = '0; fmt = 3'd7; sel = 1'b1; i1 = '0; i2 = '0; sh = 2'b00;
        case (i[6:0])
            7'h13, 7'h03, 7'h67, 7'h1b, 7'h73, 7'h0f: begin
                fmt = 3'd1; imm = {{52{i[31]}}, i[31:20]};
            end
            7'h23: begin
                fmt = 3'd2; imm = {{52{i[31]}}, i[31:25], i[11:7]};
            end
            7'h63: begin
                fmt = 3'd3; imm = {{51{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            end
            7'h37, 7'h17: begin
                fmt = 3'd4; imm = {{32{i[31]}}, i[31:12], 12'h000};
            end
            7'h6f: begin
                fmt = 3'd5; imm = {{43{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            end
            7'h33, 7'h3b: fmt = 3'd0;
            default: ;
        endcase
        case (fmt)
            3'd1, 3'd2: i1 = imm[11:0];
            3'd3: begin i1 = imm[12:1]; sh = 2'b01; end
            3'd4: begin i2 = imm[31:12]; sel = 1'b0; sh = 2'b10; end
            3'd5: begin i2 = imm[20:1]; sel = 1'b0; sh = 2'b01; end
            default: ;
        endcase
    endtask
    task automatic check_outputs();
        logic [2:0]  fmt;
        logic        sel;
        logic [11:0] i1;
        logic [19:0] i2;
        logic [1:0]  sh;
        logic [63:0] imm, ext;
        logic        v;
        v = !rst && q.size() != 0;
        chk("inst_ready", 64'(bus.inst_ready), 64'(!rst && q.size() < 2));
        chk("dec_valid", 64'(bus.dec_valid), 64'(v));
        if (v) ref_dec(q[0].inst, fmt, sel, i1, i2, sh, imm);
        else begin fmt = '0; sel = 1'b0; i1 = '0; i2 = '0; sh = '0; imm = '0; end
        chk("dec_pc", bus.dec_pc, v ? q[0].pc : 64'h0);
        chk("dec_inst", 64'(bus.dec_inst), v ? 64'(q[0].inst) : 64'h0);
        chk("fmt", 64'(bus.fmt), 64'(fmt));
        chk("illegal", 64'(bus.illegal), 64'(v && fmt == 3'd7));
        chk("immsel", 64'(bus.immsel), 64'(sel));
        chk("imm1", 64'(bus.imm1), 64'(i1));
        chk("imm2", 64'(bus.imm2), 64'(i2));
        chk("imm_sh", 64'(bus.imm_sh), 64'(sh));
        ext = bus.immsel ? {{52{bus.imm1[11]}}, bus.imm1} : {{44{bus.imm2[19]}}, bus.imm2};
        ext = bus.imm_sh == 2'b01 ? ext << 1 : bus.imm_sh == 2'b10 ? ext << 12 : ext;
        chk("arch_imm", ext, imm);
    endtask
    task automatic step(input logic v, input logic [31:0] ins, input logic [63:0] p,
                        input logic rdy, input logic fl);
        logic push, pop;
        bus.inst_valid = v; bus.inst = ins; bus.pc = p; bus.dec_ready = rdy; bus.flush = fl;
        push = !rst && v && q.size() < 2 && !fl;
        pop  = !rst && rdy && q.size() != 0 && !fl;
        @(posedge clk);
        if (rst || fl) q.delete();
        else begin
            if (pop) void'(q.pop_front());
            if (push) q.push_back('{p, ins});
        end
        @(negedge clk);
        check_outputs();
    endtask
    logic [6:0] ops [16] = '{7'h13, 7'h03, 7'h67, 7'h1b, 7'h73, 7'h0f, 7'h23, 7'h63,
                             7'h37, 7'h17, 7'h6f, 7'h33, 7'h3b, 7'h0b, 7'h10, 7'h2b};
    initial begin
        logic [31:0] r;
        rst = 1'b1;
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        rst = 1'b0;
        step(0, 0, 0, 0, 0);
        chk("ready_after_reset", 64'(bus.inst_ready), 64'h1);
        step(1, 32'hFFF00093, 64'h80000000, 0, 0);
        chk("addi_imm1", 64'(bus.imm1), 64'hFFF);
        chk("addi_fmt", 64'(bus.fmt), 64'h1);
        chk("addi_pc", bus.dec_pc, 64'h80000000);
        step(0, 0, 0, 1, 0);
        step(1, 32'hFE000EE3, 64'h80000004, 0, 0);
        chk("beq_fmt", 64'(bus.fmt), 64'h3);
        step(0, 0, 0, 1, 0);
        step(1, 32'h800000EF, 64'h80000008, 0, 0);
        chk("jal_imm2", 64'(bus.imm2), 64'h80000);
        chk("jal_immsel", 64'(bus.immsel), 64'h0);
        step(0, 0, 0, 1, 0);
        step(1, 32'h00100093, 64'h100, 0, 0);
        step(1, 32'h00200093, 64'h104, 0, 0);
        step(1, 32'h00300093, 64'h108, 0, 0);
        chk("full_ready", 64'(bus.inst_ready), 64'h0);
        step(1, 32'h00300093, 64'h108, 1, 0);
        chk("after_pop_head", 64'(bus.dec_inst), 64'h00200093);
        step(1, 32'h00300093, 64'h108, 1, 0);
        chk("third_head", bus.dec_pc, 64'h108);
        step(0, 0, 0, 1, 0);
        step(1, 32'h00400093, 64'h200, 0, 0);
        step(1, 32'h00500093, 64'h204, 0, 0);
        step(1, 32'h00600093, 64'h208, 1, 1);
        chk("flush_valid", 64'(bus.dec_valid), 64'h0);
        step(0, 0, 0, 1, 0);
        step(1, 32'h0000000B, 64'h300, 0, 0);
        chk("custom_illegal", 64'(bus.illegal), 64'h1);
        step(0, 0, 0, 1, 0);
        step(1, 32'h00000010, 64'h304, 0, 0);
        chk("low_bits_illegal", 64'(bus.fmt), 64'h7);
        step(0, 0, 0, 1, 0);
        for (int n = 0; n < 400; n++) begin
            r = $urandom;
            rst = (n == 200);
            step($urandom_range(0, 3) != 0, {r[31:7], ops[$urandom_range(0, 15)]},
                 {$urandom, $urandom}, $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
